// File: rtl/pc_pkg.sv
// Shared encodings for the 65C02 program-counter stage: command codes,
// FSM states and the default post-reset PC.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LDLO = 3'd2,
    PC_LDHI = 3'd3,
    PC_BRA  = 3'd4,
    PC_LDW  = 3'd5
  } pc_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } pc_state_e;

  localparam logic [15:0] RST_PC_DEF = 16'hFFFC;

endpackage

// File: rtl/pc_adder8.sv
// 8-bit adder with carry-out, shared between the branch low-byte add and
// the page fix-up high-byte adjust.
module pc_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/pc_unit.sv
// 65C02 program counter: increment, byte/word loads, and relative branch
// with a one-cycle page-cross fix-up of the high byte.
module pc_unit
  import pc_pkg::*;
#(
  parameter int             AW     = 16,
  parameter logic [AW-1:0]  RST_PC = RST_PC_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE,
  input  logic [2:0]    OP,
  input  logic [7:0]    DIN,
  input  logic [AW-1:0] ADDR_IN,
  output logic [AW-1:0] PC,
  output logic          BUSY,
  output logic          PCROSS
);

  localparam logic [AW-1:0] ONE = 1;

  pc_state_e     state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [7:0]    lat, lat_nxt;
  logic          dir, dir_nxt;
  logic          pcross, pcross_nxt;

  logic [7:0]    add_a, add_b, add_sum;
  logic          add_cout;

  // One adder serves both cycles: low byte + offset while idle, high byte +/- 1 in FIX.
  assign add_a = (state == ST_FIX) ? pc[15:8] : pc[7:0];
  assign add_b = (state == ST_FIX) ? (dir ? 8'hFF : 8'h01) : DIN;

  pc_adder8 u_adder (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    lat_nxt    = lat;
    dir_nxt    = dir;
    pcross_nxt = pcross;
    if (CE) begin
      pcross_nxt = 1'b0;
      case (state)
        ST_IDLE: begin
          case (OP)
            PC_INC:  pc_nxt = pc + ONE;
            PC_LDLO: lat_nxt = DIN;
            PC_LDHI: pc_nxt = {DIN, lat};
            PC_BRA: begin
              pc_nxt = {pc[15:8], add_sum};
              // Signed offset: carry disagreeing with the sign bit means the page changed.
              if (add_cout ^ DIN[7]) begin
                state_nxt = ST_FIX;
                dir_nxt   = DIN[7];
              end
            end
            PC_LDW:  pc_nxt = ADDR_IN;
            default: pc_nxt = pc;
          endcase
        end
        ST_FIX: begin
          pc_nxt     = {add_sum, pc[7:0]};
          pcross_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      pc     <= RST_PC;
      lat    <= 8'h00;
      dir    <= 1'b0;
      pcross <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      lat    <= lat_nxt;
      dir    <= dir_nxt;
      pcross <= pcross_nxt;
    end
  end

  assign PC     = pc;
  assign BUSY   = (state == ST_FIX);
  assign PCROSS = pcross;

endmodule
